multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle RV32I control FSM that sequences the shared datapath (PC, IR, register file, single ALU, immediate extender, unified memory) one instruction at a time. It decodes the opcode held in IR and drives every datapath mux select and write strobe. It also drives the extender's `imm_src` code and handshakes with memory through `mem_req`/`mem_ready`. It sits beside the datapath at the core's top level.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `op` input 7: IR[6:0].
- `funct3` input 3: IR[14:12].
- `funct7b5` input 1: IR[30]. Passed through to the ALU decoder; unused internally.
- `zero`, `lt`, `ltu` input 1 each: ALU flags for rs1−rs2, where `lt` is signed and `ltu` is unsigned.
- `mem_ready` input 1: memory completes the current request this cycle.
- `mem_req` output 1: memory access request.
- `mem_write` output 1: store strobe.
- `adr_src` output 1: memory address select, 0 = PC, 1 = ALUOut.
- `ir_write` output 1: IR and OldPC load enable.
- `pc_write` output 1: PC load enable.
- `reg_write` output 1: register-file write enable.
- `result_src` output 2: result mux select, 00 = ALUOut, 01 = Data, 10 = ALU result.
- `alu_src_a` output 2: ALU operand A select, 00 = PC, 01 = OldPC, 10 = rs1 register, 11 = zero.
- `alu_src_b` output 2: ALU operand B select, 00 = rs2 register, 01 = imm_ext, 10 = constant 4.
- `alu_op` output 2: ALU operation class, 00 = add, 01 = compare (subtract), 10 = decode from funct fields.
- `imm_src` output 3: immediate format code, I = 000, S = 001, B = 010, J = 011, U = 100.
- `illegal` output 1: sticky illegal-opcode flag.

## Operation
- The `imm_src` output is combinational from `op` and is valid in every state:
  - lw, jalr, OP-IMM: 000.
  - sw: 001.
  - branch: 010.
  - jal: 011.
  - lui, auipc: 100.
  - any other opcode: 000.
- States and their actions. Any signal not listed is 0.
  - **FETCH:** `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `result_src`=10. When `mem_ready`=1: `ir_write`=1, `pc_write`=1, go to DECODE. Otherwise stay in FETCH.
  - **DECODE:** `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00, so ALUOut ← OldPC+imm. Next state by opcode:
    - lw/sw → MEMADR.
    - OP → EXECR.
    - OP-IMM → EXECI.
    - branch → BRANCH.
    - jal → JAL.
    - jalr → JALR.
    - lui → LUI.
    - auipc → ALUWB.
    - anything else → ILLEGAL.
  - **MEMADR:** `alu_src_a`=10, `alu_src_b`=01. Go to MEMREAD for lw, MEMWRITE for sw.
  - **MEMREAD:** `mem_req`=1, `adr_src`=1, `result_src`=00. Wait in this state until `mem_ready`=1, then go to MEMWB.
  - **MEMWB:** `result_src`=01, `reg_write`=1. Go to FETCH.
  - **MEMWRITE:** `mem_req`=1, `mem_write`=1, `adr_src`=1, `result_src`=00. Both strobes are held until `mem_ready`=1, then go to FETCH.
  - **EXECR:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Go to ALUWB.
  - **EXECI:** `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Go to ALUWB.
  - **ALUWB:** `result_src`=00, `reg_write`=1. Go to FETCH.
  - **BRANCH:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `pc_write`=taken. Go to FETCH.
    - funct3 000: taken = `zero`.
    - funct3 001: taken = !`zero`.
    - funct3 100: taken = `lt`.
    - funct3 101: taken = !`lt`.
    - funct3 110: taken = `ltu`.
    - funct3 111: taken = !`ltu`.
    - funct3 010/011: not taken.
  - **JAL:** `alu_src_a`=01, `alu_src_b`=10, `result_src`=00, `pc_write`=1. Go to ALUWB, which writes OldPC+4 to rd.
  - **JALR:** `alu_src_a`=10, `alu_src_b`=01, so ALUOut ← rs1+imm. Go to JAL.
  - **LUI:** `alu_src_a`=11, `alu_src_b`=01. Go to ALUWB.
  - **ILLEGAL:** behaviour set by the macro; see Configuration.
- `illegal` is set on entry to ILLEGAL and is cleared only by `reset`.

## Timing
- Reset: the state register goes to FETCH asynchronously and `illegal` clears to 0. While `reset` is high, all outputs are at their FETCH values, except that `ir_write` and `pc_write` are forced to 0.
- Outputs are Moore, except:
  - `ir_write` and `pc_write` in FETCH, gated by `mem_ready`.
  - `pc_write` in BRANCH, gated by taken.
- Zero-wait-state cycle counts:
  - lw 5, sw 4.
  - R-type 4, I-type 4.
  - branch 3.
  - jal 4, jalr 5.
  - lui 4, auipc 3.
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. All outputs stay stable while waiting.
- `mem_ready` is ignored in every other state.
- If `reset` asserts during a memory wait, `mem_req` and `mem_write` continue with their FETCH values (`mem_req`=1, `mem_write`=0, `adr_src`=0). No datapath register write occurs.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined: ILLEGAL is absorbing. All strobes are 0 and `illegal`=1 until `reset`.
- `MC_ILLEGAL_TRAP_EN` undefined: ILLEGAL acts as a one-cycle NOP with no strobes and returns to FETCH. `illegal` is tied to 0.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encoding, 4 bits.
  - opcode constants.
  - `imm_src` codes.
  - `result_src`, `alu_src_a`, `alu_src_b` and `alu_op` encodings.
- Sub-module `branch_cond`: combinational, takes (`funct3`, `zero`, `lt`, `ltu`) and produces taken.

## Test plan
- **Reset and fetch:** assert `reset`, release, hold `mem_ready`=1 → state FETCH with `mem_req`=1; next edge gives `ir_write`=`pc_write`=1 and the FSM enters DECODE.
- **lw with waits:** `op`=0000011 with `mem_ready`=0 for 2 cycles in MEMREAD → 7 cycles total; MEMWB asserts `reg_write`=1 and `result_src`=01; `imm_src`=000.
- **Branches:** `op`=1100011.
  - `funct3`=001, `zero`=1 → `pc_write`=0 in BRANCH.
  - `funct3`=110, `ltu`=1 → `pc_write`=1 in BRANCH.
  - Both cases take 3 cycles and `imm_src`=010.
- **jalr:** `op`=1100111 → FSM sequence FETCH, DECODE, JALR, JAL, ALUWB; `pc_write`=1 only in FETCH and JAL.
- **sw handshake:** `op`=0100011 with `mem_ready` low for 3 cycles → `mem_write`=1 held for 4 cycles; `imm_src`=001.
- **Illegal opcode and mid-wait reset:**
  - `op`=1111111 with the macro defined → `illegal`=1 and the FSM stays in ILLEGAL.
  - `op`=1111111 with the macro undefined → FETCH after 3 cycles.
  - `reset` pulsed during the MEMREAD wait → immediate return to FETCH with `reg_write`=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM.
// Opcodes, state encoding, imm_src codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CMP   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Immediate format follows the opcode alone, independent of FSM state.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] r;
        r = IMM_I;
        case (op)
            OP_STORE:         r = IMM_S;
            OP_BRANCH:        r = IMM_B;
            OP_JAL:           r = IMM_J;
            OP_LUI, OP_AUIPC: r = IMM_U;
            default:          r = IMM_I;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_branch_cond.sv
// Branch resolution from ALU compare flags of rs1-rs2.
// Purely combinational; reserved funct3 codes never branch.
module branch_cond
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);

    // Select the flag (or its inverse) that this branch kind tests.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM driving the shared datapath.
// MC_ILLEGAL_TRAP_EN makes the ILLEGAL state absorbing with a sticky flag.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal
);

    state_e state_q, state_d;
    logic   taken;
    logic   funct7b5_unused;

    // funct7b5 only matters to the ALU decoder beside us.
    assign funct7b5_unused = funct7b5;

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .ltu    (ltu),
        .taken  (taken)
    );

    assign imm_src = imm_src_of(op);

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    // Flag rises together with the first cycle spent in ILLEGAL.
    always_comb begin
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Next-state selection; memory states hold until mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_OP:             state_d = S_EXECR;
                    OP_IMM:            state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            S_LUI:      state_d = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
            S_ILLEGAL:  state_d = S_ILLEGAL;
`else
            S_ILLEGAL:  state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // State register; reset lands in FETCH and clears the sticky flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Moore decode of selects; fetch and branch strobes gate on inputs.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready & ~reset;
                pc_write   = mem_ready & ~reset;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_CMP;
                pc_write  = taken;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: random instruction stream with a
// memory responder inserting random wait states, plus directed corner cases.
module tb_multicycle_ctrl;

    localparam int N = 60;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, lt, ltu, mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic       illegal;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int          fw;
        int          mw;
    } ins_t;

    typedef struct {
        int         cyc;
        int         pcw;
        int         rgw;
        int         mwc;
        logic [2:0] imm;
        logic [1:0] rs;
    } exp_t;

    ins_t recs[N+2];
    exp_t expq[$];
    int   n_chk, n_fail, pops, ir_count;
    bit   auto_mem, mon_en;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural branch outcome from the operand values themselves.
    function automatic bit br_taken(input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Per-instruction totals: cycles, strobe counts, imm format.
    function automatic exp_t model(input ins_t i);
        exp_t e;
        int   base;
        e.pcw = 1;
        e.rgw = 1;
        e.mwc = 0;
        e.imm = 3'b000;
        e.rs  = 2'b00;
        base  = 3;
        case (i.op)
            7'b0000011: begin base = 5 + i.mw; e.rs = 2'b01; end
            7'b0100011: begin base = 4 + i.mw; e.rgw = 0;
                              e.mwc = 1 + i.mw; e.imm = 3'b001; end
            7'b0110011: base = 4;
            7'b0010011: base = 4;
            7'b1100011: begin base = 3; e.rgw = 0; e.imm = 3'b010;
                              e.pcw = 1 + int'(br_taken(i.f3, i.a, i.b)); end
            7'b1101111: begin base = 4; e.pcw = 2; e.imm = 3'b011; end
            7'b1100111: begin base = 5; e.pcw = 2; end
            7'b0110111: begin base = 4; e.imm = 3'b100; end
            7'b0010111: begin base = 3; e.imm = 3'b100; end
            default:    begin base = 3; e.rgw = 0; end
        endcase
        e.cyc = base + i.fw;
        return e;
    endfunction

    function automatic logic [31:0] pickv();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic apply(input ins_t i);
        op     = i.op;
        funct3 = i.f3;
        zero   = (i.a == i.b);
        lt     = ($signed(i.a) < $signed(i.b));
        ltu    = (i.a < i.b);
    endtask

    task automatic score(input int cyc, input int pcw, input int rgw,
                         input int mwc, input logic [2:0] imm,
                         input logic [1:0] rs, input int ill);
        exp_t e;
        if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty: got instr expected none");
        end else begin
            e = expq.pop_front();
            chk("cycles", cyc, e.cyc);
            chk("pc_write_cnt", pcw, e.pcw);
            chk("reg_write_cnt", rgw, e.rgw);
            chk("mem_write_cnt", mwc, e.mwc);
            chk("imm_src", int'(imm), int'(e.imm));
            if (e.rgw > 0) chk("wb_result_src", int'(rs), int'(e.rs));
            chk("illegal_cnt", ill, 0);
        end
        pops++;
    endtask

    // Memory responder: releases each request after its random wait count.
    initial begin
        int cnt;
        bit active;
        int idx;
        cnt = 0;
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (!auto_mem) begin
                active = 1'b0;
            end else begin
                if (mem_ready) active = 1'b0;
                mem_ready = 1'b0;
                if (mem_req) begin
                    if (!active) begin
                        active = 1'b1;
                        idx = adr_src ? ir_count - 1 : ir_count;
                        if (idx < 0 || idx > N + 1) idx = 0;
                        cnt = adr_src ? recs[idx].mw : recs[idx].fw;
                    end
                    if (cnt == 0) mem_ready = 1'b1;
                    else cnt--;
                end
            end
        end
    end

    // Instruction supply: IR loads on each ir_write; expectation queued.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (auto_mem && ir_write && ir_count <= N) begin
                expq.push_back(model(recs[ir_count]));
                @(posedge clk);
                #1;
                apply(recs[ir_count]);
                ir_count++;
            end
        end
    end

    // Monitor: an instruction spans one fetch start to the next.
    initial begin
        int         cyc, pcw, rgw, mwc, ill;
        logic [2:0] imm;
        logic [1:0] rs;
        bit         inprog, prev_fw, after_ir, fetch;
        cyc = 0; pcw = 0; rgw = 0; mwc = 0; ill = 0;
        imm = '0; rs = '0;
        inprog = 0; prev_fw = 0; after_ir = 0;
        forever begin
            @(negedge clk);
            #3;
            if (!mon_en) begin
                inprog = 0;
                prev_fw = 0;
                after_ir = 0;
            end else begin
                fetch = mem_req && !adr_src;
                if (fetch && !prev_fw) begin
                    if (inprog) score(cyc, pcw, rgw, mwc, imm, rs, ill);
                    inprog = 1;
                    cyc = 0; pcw = 0; rgw = 0; mwc = 0; ill = 0;
                    imm = 3'b111;
                    rs = 2'b11;
                end
                prev_fw = fetch && !ir_write;
                cyc++;
                pcw += int'(pc_write);
                rgw += int'(reg_write);
                mwc += int'(mem_write);
                if (reg_write) rs = result_src;
                if (after_ir) imm = imm_src;
                after_ir = ir_write;
                if (illegal) ill++;
            end
        end
    end

    initial begin
        logic [6:0] ops[11];
        int         nops;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                7'b0010111, 7'b1111111, 7'b0001011};
`ifdef MC_ILLEGAL_TRAP_EN
        nops = 9;
`else
        nops = 11;
`endif
        foreach (recs[k]) begin
            recs[k].op = ops[$urandom_range(0, nops - 1)];
            recs[k].f3 = 3'($urandom_range(0, 7));
            recs[k].a  = pickv();
            recs[k].b  = pickv();
            recs[k].fw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            recs[k].mw = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 4) : 0;
        end
        n_chk = 0; n_fail = 0; pops = 0; ir_count = 0;
        auto_mem = 0; mon_en = 0;
        reset = 1'b1; mem_ready = 1'b1;
        op = 7'b0010011; funct3 = 3'd0; funct7b5 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0;

        // Reset state: FETCH selects, fetch strobes held off.
        repeat (2) @(negedge clk);
        #3;
        chk("rst_mem_req", mem_req, 1);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_adr_src", adr_src, 0);
        chk("rst_src_a", alu_src_a, 0);
        chk("rst_src_b", alu_src_b, 2);
        chk("rst_result_src", result_src, 2);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_illegal", illegal, 0);

        @(posedge clk);
        #2;
        reset = 1'b0;
        mon_en = 1;
        auto_mem = 1;
        for (int c = 0; c < 20000 && pops < N; c++) @(posedge clk);
        if (pops < N) begin
            n_chk++;
            n_fail++;
            $display("FAIL random_timeout: got %0d instrs expected %0d", pops, N);
        end
        auto_mem = 0;
        mon_en = 0;

        // Directed: fetch with ready, lw, reset during MEMREAD wait.
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        op = 7'b0000011;
        funct3 = 3'd2;
        @(negedge clk);
        reset = 1'b0;
        #3;
        chk("fetch_ir_write", ir_write, 1);
        chk("fetch_pc_write", pc_write, 1);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        chk("decode_src_a", alu_src_a, 1);
        chk("decode_src_b", alu_src_b, 1);
        chk("decode_mem_req", mem_req, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("memread_req", mem_req, 1);
        chk("memread_adr", adr_src, 1);
        @(posedge clk);
        #1;
        chk("memread_wait_req", mem_req, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_mem_req", mem_req, 1);
        chk("midrst_adr_src", adr_src, 0);
        chk("midrst_reg_write", reg_write, 0);
        chk("midrst_mem_write", mem_write, 0);
        mem_ready = 1'b1;
        #1;
        chk("midrst_ir_write", ir_write, 0);
        @(negedge clk);
        reset = 1'b0;
        op = 7'b1111111;
        #1;
        chk("post_rst_fetch", ir_write, 1);

        // Directed: illegal opcode handling.
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("illegal_no_req", mem_req, 0);
`ifdef MC_ILLEGAL_TRAP_EN
        chk("illegal_flag", illegal, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("illegal_stuck_flag", illegal, 1);
        chk("illegal_stuck_req", mem_req, 0);
        chk("illegal_stuck_pcw", pc_write, 0);
`else
        chk("illegal_flag_tied", illegal, 0);
        @(posedge clk);
        #1;
        chk("illegal_back_fetch", mem_req, 1);
        chk("illegal_back_adr", adr_src, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
